// File: rtl/alu_reservation_station.sv
// Integer-ALU reservation station: a compacting queue of decoded ALU ops that
// waits for both operands (snooping the CDB) and issues the oldest ready entry.
module alu_reservation_station #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned TAG_W       = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               dispatch_valid,
  input  logic [TAG_W+107:0] dc2rs,
  output logic               rs_full,
  input  logic               cdb_valid,
  input  logic [TAG_W-1:0]   cdb_tag,
  input  logic [31:0]        cdb_data,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [9:0]         issue_inst,
  output logic [TAG_W-1:0]   issue_dest,
  output logic [31:0]        issue_opr1,
  output logic [31:0]        issue_opr2
);

  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

  // Registered entry state; index 0 is always the oldest entry.
  logic             r_valid [NUM_ENTRIES];
  logic [9:0]       r_inst  [NUM_ENTRIES];
  logic [TAG_W-1:0] r_dest  [NUM_ENTRIES];
  logic             r_v1    [NUM_ENTRIES];
  logic [31:0]      r_d1    [NUM_ENTRIES];
  logic             r_v2    [NUM_ENTRIES];
  logic [31:0]      r_d2    [NUM_ENTRIES];
  logic [CNT_W-1:0] r_count;

  // Woken copies of each entry; the extra top slot is an always-empty entry
  // that gets shifted into the last index when something is removed.
  logic             w_wk_valid [NUM_ENTRIES+1];
  logic [9:0]       w_wk_inst  [NUM_ENTRIES+1];
  logic [TAG_W-1:0] w_wk_dest  [NUM_ENTRIES+1];
  logic             w_wk_v1    [NUM_ENTRIES+1];
  logic [31:0]      w_wk_d1    [NUM_ENTRIES+1];
  logic             w_wk_v2    [NUM_ENTRIES+1];
  logic [31:0]      w_wk_d2    [NUM_ENTRIES+1];

  logic             w_nxt_valid [NUM_ENTRIES];
  logic [9:0]       w_nxt_inst  [NUM_ENTRIES];
  logic [TAG_W-1:0] w_nxt_dest  [NUM_ENTRIES];
  logic             w_nxt_v1    [NUM_ENTRIES];
  logic [31:0]      w_nxt_d1    [NUM_ENTRIES];
  logic             w_nxt_v2    [NUM_ENTRIES];
  logic [31:0]      w_nxt_d2    [NUM_ENTRIES];
  logic [CNT_W-1:0] w_nxt_count;

  logic             w_any_ready;
  logic [CNT_W-1:0] w_sel;
  logic             w_fire;
  logic             w_accept;
  logic [CNT_W-1:0] w_wr_idx;

  // Incoming packet fields; the offset field is not needed on the ALU path.
  logic [9:0]       w_in_inst;
  logic [TAG_W-1:0] w_in_dest;
  logic [32:0]      w_in_op1;
  logic [32:0]      w_in_op2;
  logic             w_in_v1;
  logic [31:0]      w_in_d1;
  logic             w_in_v2;
  logic [31:0]      w_in_d2;
  logic             w_unused_offset;

  assign w_in_inst       = dc2rs[TAG_W+107 -: 10];
  assign w_in_dest       = dc2rs[TAG_W+97 -: TAG_W];
  assign w_in_op1        = dc2rs[97:65];
  assign w_in_op2        = dc2rs[64:32];
  assign w_unused_offset = ^dc2rs[31:0];

  assign rs_full  = (r_count == CNT_W'(NUM_ENTRIES));
  assign w_accept = dispatch_valid && !rs_full;
  assign w_fire   = issue_valid && issue_ready;
  // After a same-cycle removal everything shifts down, so the new slot is one lower.
  assign w_wr_idx = r_count - CNT_W'(w_fire);

  // Dispatch bypass: an operand being broadcast this cycle is written already woken.
  always_comb begin
    w_in_v1 = w_in_op1[32];
    w_in_d1 = w_in_op1[31:0];
    w_in_v2 = w_in_op2[32];
    w_in_d2 = w_in_op2[31:0];
    if (cdb_valid && !w_in_op1[32] && (w_in_op1[TAG_W-1:0] == cdb_tag)) begin
      w_in_v1 = 1'b1;
      w_in_d1 = cdb_data;
    end
    if (cdb_valid && !w_in_op2[32] && (w_in_op2[TAG_W-1:0] == cdb_tag)) begin
      w_in_v2 = 1'b1;
      w_in_d2 = cdb_data;
    end
  end

  // CDB wakeup applied to every stored entry.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_wk_valid[i] = r_valid[i];
      w_wk_inst[i]  = r_inst[i];
      w_wk_dest[i]  = r_dest[i];
      w_wk_v1[i]    = r_v1[i];
      w_wk_d1[i]    = r_d1[i];
      w_wk_v2[i]    = r_v2[i];
      w_wk_d2[i]    = r_d2[i];
      if (cdb_valid && r_valid[i] && !r_v1[i] && (r_d1[i][TAG_W-1:0] == cdb_tag)) begin
        w_wk_v1[i] = 1'b1;
        w_wk_d1[i] = cdb_data;
      end
      if (cdb_valid && r_valid[i] && !r_v2[i] && (r_d2[i][TAG_W-1:0] == cdb_tag)) begin
        w_wk_v2[i] = 1'b1;
        w_wk_d2[i] = cdb_data;
      end
    end
    w_wk_valid[NUM_ENTRIES] = 1'b0;
    w_wk_inst[NUM_ENTRIES]  = '0;
    w_wk_dest[NUM_ENTRIES]  = '0;
    w_wk_v1[NUM_ENTRIES]    = 1'b0;
    w_wk_d1[NUM_ENTRIES]    = '0;
    w_wk_v2[NUM_ENTRIES]    = 1'b0;
    w_wk_d2[NUM_ENTRIES]    = '0;
  end

  // Oldest-ready select and combinational issue outputs from registered state.
  always_comb begin
    w_any_ready = 1'b0;
    w_sel       = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && r_v1[i] && r_v2[i]) begin
        w_any_ready = 1'b1;
        w_sel       = CNT_W'(i);
      end
    end
    issue_valid = w_any_ready;
    issue_inst  = '0;
    issue_dest  = '0;
    issue_opr1  = '0;
    issue_opr2  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_any_ready && (CNT_W'(i) == w_sel)) begin
        issue_inst = r_inst[i];
        issue_dest = r_dest[i];
        issue_opr1 = r_d1[i];
        issue_opr2 = r_d2[i];
      end
    end
  end

  // Next state: compact out the issued entry, append dispatch, flush wins over all.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_fire && (CNT_W'(i) >= w_sel)) begin
        w_nxt_valid[i] = w_wk_valid[i+1];
        w_nxt_inst[i]  = w_wk_inst[i+1];
        w_nxt_dest[i]  = w_wk_dest[i+1];
        w_nxt_v1[i]    = w_wk_v1[i+1];
        w_nxt_d1[i]    = w_wk_d1[i+1];
        w_nxt_v2[i]    = w_wk_v2[i+1];
        w_nxt_d2[i]    = w_wk_d2[i+1];
      end else begin
        w_nxt_valid[i] = w_wk_valid[i];
        w_nxt_inst[i]  = w_wk_inst[i];
        w_nxt_dest[i]  = w_wk_dest[i];
        w_nxt_v1[i]    = w_wk_v1[i];
        w_nxt_d1[i]    = w_wk_d1[i];
        w_nxt_v2[i]    = w_wk_v2[i];
        w_nxt_d2[i]    = w_wk_d2[i];
      end
      if (w_accept && (CNT_W'(i) == w_wr_idx)) begin
        w_nxt_valid[i] = 1'b1;
        w_nxt_inst[i]  = w_in_inst;
        w_nxt_dest[i]  = w_in_dest;
        w_nxt_v1[i]    = w_in_v1;
        w_nxt_d1[i]    = w_in_d1;
        w_nxt_v2[i]    = w_in_v2;
        w_nxt_d2[i]    = w_in_d2;
      end
      if (flush) begin
        w_nxt_valid[i] = 1'b0;
      end
    end
    w_nxt_count = r_count + CNT_W'(w_accept) - CNT_W'(w_fire);
    if (flush) begin
      w_nxt_count = '0;
    end
  end

  // Entry and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_inst[i]  <= '0;
        r_dest[i]  <= '0;
        r_v1[i]    <= 1'b0;
        r_d1[i]    <= '0;
        r_v2[i]    <= 1'b0;
        r_d2[i]    <= '0;
      end
    end else begin
      r_count <= w_nxt_count;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_valid[i] <= w_nxt_valid[i];
        r_inst[i]  <= w_nxt_inst[i];
        r_dest[i]  <= w_nxt_dest[i];
        r_v1[i]    <= w_nxt_v1[i];
        r_d1[i]    <= w_nxt_d1[i];
        r_v2[i]    <= w_nxt_v2[i];
        r_d2[i]    <= w_nxt_d2[i];
      end
    end
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Integer-ALU reservation station. Sits directly downstream of decode: accepts the 114-bit dc2rs packet when decode's rs_dest bit 3 (ALU) is set.
- Holds instructions until both operands are valid, snooping the common data bus (CDB) for ROB-tag results.
- Issues the oldest ready instruction to the ALU via a valid/ready handshake.

Parameters:
- NUM_ENTRIES, 4, station depth (2..8).
- TAG_W, 6, ROB tag width (matches dest_rob).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all entries (misprediction).
- dispatch_valid  input  1  dispatch request; driven from decode rs_dest[3].
- dc2rs  input  114  {rs_inst[9:0], dest_rob[5:0], opr1[32:0], opr2[32:0], offset[31:0]}.
- rs_full  output  1  no free entry; dispatch is not accepted this cycle.
- cdb_valid  input  1  CDB broadcast valid.
- cdb_tag  input  6  ROB tag of the broadcast result.
- cdb_data  input  32  broadcast result value.
- issue_valid  output  1  a ready entry is presented.
- issue_ready  input  1  ALU accepts this cycle.
- issue_inst  output  10  rs_inst of the presented entry.
- issue_dest  output  6  dest_rob of the presented entry.
- issue_opr1  output  32  operand 1 value.
- issue_opr2  output  32  operand 2 value.

Behaviour:
- Operand encoding is {v, payload[31:0]}.
  - v=1: payload is the value.
  - v=0: payload[5:0] is the producing ROB tag; payload[31:6] is ignored.
- offset is discarded; the ALU path does not use it.
- Entry contents: valid, inst, dest, v1, d1, v2, d2. Storage is a compacting queue: index 0 is the oldest; new entries go at index = count.
- Reset (rst_n low, asynchronous): all valid bits cleared, count=0. Outputs issue_valid=0, rs_full=0; issue_inst, issue_dest and issue_opr1/2 are 0.
- rs_full = (count == NUM_ENTRIES), derived combinationally from registered count.
- Dispatch is accepted iff dispatch_valid && !rs_full. There is no same-cycle pass-through: a dispatch into a full station is dropped even if an issue happens the same cycle. Upstream must stall on rs_full.
- Wakeup: on cdb_valid, every valid entry with v1=0 and d1[5:0]==cdb_tag captures d1=cdb_data and sets v1=1. Operand 2 is handled the same way. The update is registered.
- Dispatch bypass: if cdb_valid matches a not-valid operand of the incoming dc2rs in the same cycle, the entry is written already woken with cdb_data.
- Ready = valid && v1 && v2, evaluated on registered state. An entry woken in cycle N is first eligible in cycle N+1. An entry dispatched with both operands valid is eligible the cycle after dispatch. Minimum dispatch-to-issue latency is 1 cycle.
- Select: issue_valid = any ready entry. The presented entry is the lowest-index (oldest) ready entry. issue_* come combinationally from that entry.
- Transfer occurs on issue_valid && issue_ready.
  - Next edge: the selected entry is removed.
  - Entries above it shift down one index, with any same-cycle wakeup applied to the shifted copies.
  - count decrements.
- Simultaneous dispatch + issue: the new entry is written at index count-1 (after the shift), so count is unchanged.
- With issue_valid=1 and issue_ready=0, issue_* must hold stable unless an older entry becomes ready.
- flush: next edge clears all entries, count=0. Flush has priority over dispatch, issue and wakeup in the same cycle.
- A CDB tag matching no entry has no effect. Multiple entries matching one tag all wake.

Test Plan:
- Reset: rst_n=0 mid-stream with 3 entries held → immediately issue_valid=0, rs_full=0; after release, count=0 and no issue.
- Ready dispatch: ADDI (inst=0x000, dest=5, opr1={1,0x10}, opr2={1,0x3}) with issue_ready=1 → next cycle issue_valid=1, issue_dest=5, opr1=0x10, opr2=0x3; the cycle after, issue_valid=0.
- Wakeup: dispatch opr1={0,tag 9}, opr2={1,7}. Cycle N: cdb_valid, tag=9, data=0xDEAD → issue_valid=0 in N, =1 in N+1 with opr1=0xDEAD.
- Bypass: dispatch with opr2 tag 12 while the CDB broadcasts tag 12 / data 0x55 in the same cycle → issues next cycle with opr2=0x55.
- Full/ordering: issue_ready=0, dispatch 4 ready entries dest 1..4 → rs_full=1, and a 5th dispatch is dropped. Then issue_ready=1 → dests issue in order 1,2,3,4 on consecutive cycles; rs_full drops after the first transfer.
- Oldest-ready and flush: entry0 waits on tag 3, entry1 is ready → entry1 issues first. A flush with dispatch_valid=1 in the same cycle → count=0, nothing retained.
